// File: rtl/mpm_pkg.sv
// Shared definitions for the multi-project pad mux: register map, FSM states, STATUS layout.
package mpm_pkg;

    localparam logic [31:0] OFS_ACTIVE_REQ = 32'h0000_0000;
    localparam logic [31:0] OFS_OEB_LO     = 32'h0000_0004;
    localparam logic [31:0] OFS_OEB_HI     = 32'h0000_0008;
    localparam logic [31:0] OFS_STATUS     = 32'h0000_000C;
    localparam logic [31:0] OFS_SOFT_RST   = 32'h0000_0010;

    localparam int unsigned STATUS_CUR_LSB  = 0;
    localparam int unsigned STATUS_CUR_W    = 8;
    localparam int unsigned STATUS_BUSY_BIT = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } mpm_state_e;

endpackage

// File: rtl/mpm_wb_regs.sv
// Wishbone register file for the project mux: one ack per transfer, read data only in the ack cycle.
module mpm_wb_regs
    import mpm_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS = 8,
    parameter int unsigned IO_PADS      = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [7:0]              cur_i,
    input  logic                    busy_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [7:0]              active_req_o,
    output logic [IO_PADS-1:0]      oeb_o,
    output logic [NUM_PROJECTS-1:0] soft_rst_o,
    output logic                    active_wr_c
);

    localparam int unsigned HI_W = IO_PADS - 32;

    logic                    valid_q, valid_d;
    logic                    ack_q, ack_d;
    logic [31:0]             dat_q, dat_d;
    logic [7:0]              req_q, req_d;
    logic [IO_PADS-1:0]      oeb_q, oeb_d;
    logic [NUM_PROJECTS-1:0] soft_q, soft_d;

    logic        valid_c;
    logic        start_c;
    logic        wr_c;
    logic        full_sel_c;
    logic [31:0] ofs_c;
    logic [31:0] status_c;
    logic [31:0] rdata_c;

    // A transfer starts on the first cycle of a cyc&stb assertion, so a held strobe acks only once.
    always_comb begin
        valid_c    = wbs_cyc_i & wbs_stb_i;
        start_c    = valid_c & ~valid_q;
        wr_c       = start_c & wbs_we_i & (wbs_sel_i != 4'h0);
        full_sel_c = (wbs_sel_i == 4'hF);
        ofs_c      = wbs_adr_i - BASE_ADDR;

        status_c = '0;
        status_c[STATUS_CUR_LSB +: STATUS_CUR_W] = cur_i;
        status_c[STATUS_BUSY_BIT]                = busy_i;

        case (ofs_c)
            OFS_ACTIVE_REQ: rdata_c = {24'h0, req_q};
            OFS_OEB_LO:     rdata_c = oeb_q[31:0];
            OFS_OEB_HI:     rdata_c = 32'(oeb_q[IO_PADS-1:32]);
            OFS_STATUS:     rdata_c = status_c;
            OFS_SOFT_RST:   rdata_c = 32'(soft_q);
            default:        rdata_c = '0;
        endcase
    end

    // Next-state for the bus handshake and the writable registers.
    always_comb begin
        valid_d     = valid_c;
        ack_d       = start_c;
        dat_d       = (start_c && !wr_c) ? rdata_c : 32'h0;
        req_d       = req_q;
        oeb_d       = oeb_q;
        soft_d      = soft_q;
        active_wr_c = 1'b0;

        if (wr_c) begin
            if (ofs_c == OFS_ACTIVE_REQ && wbs_sel_i[0]) begin
                req_d       = wbs_dat_i[7:0];
                active_wr_c = 1'b1;
            end
            if (full_sel_c) begin
                case (ofs_c)
                    OFS_OEB_LO:   oeb_d[31:0]         = wbs_dat_i;
                    OFS_OEB_HI:   oeb_d[IO_PADS-1:32] = wbs_dat_i[HI_W-1:0];
                    OFS_SOFT_RST: soft_d              = wbs_dat_i[NUM_PROJECTS-1:0];
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            req_q   <= '0;
            oeb_q   <= '1;
            soft_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            req_q   <= req_d;
            oeb_q   <= oeb_d;
            soft_q  <= soft_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign active_req_o = req_q;
    assign oeb_o        = oeb_q;
    assign soft_rst_o   = soft_q;

endmodule

// File: rtl/multi_project_mux.sv
// Selects one of NUM_PROJECTS user projects onto the pads, with a reset/drain window on every switch.
module multi_project_mux
    import mpm_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS = 8,
    parameter int unsigned IO_PADS      = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned SWITCH_HOLD  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [31:0]                     wbs_adr_i,
    input  logic [31:0]                     wbs_dat_i,
    output logic                            wbs_ack_o,
    output logic [31:0]                     wbs_dat_o,
    input  logic [IO_PADS-1:0]              io_in,
    output logic [IO_PADS-1:0]              io_out,
    output logic [IO_PADS-1:0]              io_oeb,
    input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_out,
    output logic [NUM_PROJECTS*IO_PADS-1:0] proj_in,
    output logic [NUM_PROJECTS-1:0]         proj_reset
);

    localparam int unsigned       CNT_W    = $clog2(SWITCH_HOLD + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SWITCH_HOLD);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    mpm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cur_q, cur_d;

    logic [7:0]              active_req;
    logic [IO_PADS-1:0]      oeb;
    logic [NUM_PROJECTS-1:0] soft_rst;
    logic                    active_wr_c;
    logic                    busy;

    assign busy = (state_q == ST_DRAIN);

    mpm_wb_regs #(
        .NUM_PROJECTS (NUM_PROJECTS),
        .IO_PADS      (IO_PADS),
        .BASE_ADDR    (BASE_ADDR)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .cur_i        (cur_q),
        .busy_i       (busy),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .active_req_o (active_req),
        .oeb_o        (oeb),
        .soft_rst_o   (soft_rst),
        .active_wr_c  (active_wr_c)
    );

    // A new ACTIVE_REQ write always restarts the drain, even mid-drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;

        if (active_wr_c) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_LOAD;
        end else if (state_q == ST_DRAIN) begin
            if (cnt_q == CNT_ONE) begin
                state_d = ST_RUN;
                cur_d   = active_req;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CNT_LOAD;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
        end
    end

    // Pads are isolated unless running a valid project; out-of-range selections leave everything parked.
    always_comb begin
        io_out     = '0;
        io_oeb     = '1;
        proj_in    = '0;
        proj_reset = '1;
        if (state_q == ST_RUN) begin
            for (int p = 0; p < NUM_PROJECTS; p++) begin
                if (cur_q == 8'(p)) begin
                    io_out                        = proj_out[p*IO_PADS +: IO_PADS];
                    io_oeb                        = oeb;
                    proj_in[p*IO_PADS +: IO_PADS] = io_in;
                    proj_reset[p]                 = soft_rst[p];
                end
            end
        end
    end

endmodule
